touchscreen_event_decoder: RTL and testbench

Consumer end of the packed touchscreen word stream: accepts 32-bit words `{4'h8, X[11:0], 4'h0, Y[11:0]}` over the STB/ACK handshake and validates the tag fields. It turns raw coordinate samples into touch events (PRESS, MOVE, RELEASE) with a move threshold and a release timeout. Sits between the touchscreen interface output and the GUI/host event queue.

---
 rtl/touchscreen_pkg.sv | 27 ++
 rtl/touchscreen_delta_cmp.sv | 27 ++
 rtl/touchscreen_event_decoder.sv | 144 ++++++++++++++
 tb/tb_touchscreen_event_decoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/touchscreen_pkg.sv
// Shared definitions for the packed touchscreen word stream: tag, field positions, event codes.
package touchscreen_pkg;

  localparam int TS_COORD_W = 12;

  localparam logic [3:0] TS_TAG = 4'h8;

  // Word layout {tag[3:0], X[11:0], zero[3:0], Y[11:0]}
  localparam int TS_TAG_MSB = 31;
  localparam int TS_TAG_LSB = 28;
  localparam int TS_X_MSB   = 27;
  localparam int TS_X_LSB   = 16;
  localparam int TS_PAD_MSB = 15;
  localparam int TS_PAD_LSB = 12;
  localparam int TS_Y_MSB   = 11;
  localparam int TS_Y_LSB   = 0;

  localparam logic [1:0] TS_EVT_PRESS   = 2'd1;
  localparam logic [1:0] TS_EVT_MOVE    = 2'd2;
  localparam logic [1:0] TS_EVT_RELEASE = 2'd3;

  typedef enum logic {
    TS_IDLE    = 1'b0,
    TS_TOUCHED = 1'b1
  } ts_state_e;

endpackage

// File: rtl/touchscreen_delta_cmp.sv
// Per-axis movement detector: true when either axis moved strictly more than the threshold.
module touchscreen_delta_cmp
  import touchscreen_pkg::*;
(
  input  logic [TS_COORD_W-1:0] new_x,
  input  logic [TS_COORD_W-1:0] new_y,
  input  logic [TS_COORD_W-1:0] last_x,
  input  logic [TS_COORD_W-1:0] last_y,
  input  logic [TS_COORD_W:0]   thresh,
  output logic                  moved
);

  logic signed [TS_COORD_W:0] dx;
  logic signed [TS_COORD_W:0] dy;
  logic        [TS_COORD_W:0] adx;
  logic        [TS_COORD_W:0] ady;

  // One extra bit keeps the difference signed, so 0x002 -> 0xFFE is a large move, not a wrap.
  always_comb begin
    dx    = $signed({1'b0, new_x}) - $signed({1'b0, last_x});
    dy    = $signed({1'b0, new_y}) - $signed({1'b0, last_y});
    adx   = dx[TS_COORD_W] ? $unsigned(-dx) : $unsigned(dx);
    ady   = dy[TS_COORD_W] ? $unsigned(-dy) : $unsigned(dy);
    moved = (adx > thresh) || (ady > thresh);
  end

endmodule

// File: rtl/touchscreen_event_decoder.sv
// Turns validated touchscreen samples into PRESS/MOVE/RELEASE events with a one-slot output register.
// Handshakes: a transfer happens on a rising CLK edge where STB & ACK; STB is held until then.
module touchscreen_event_decoder
  import touchscreen_pkg::*;
#(
  parameter int RELEASE_TIMEOUT = 50000,
  parameter int MOVE_THRESH     = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_STB,
  output logic        I_ACK,
  input  logic [31:0] I_DAT,
  output logic        O_STB,
  input  logic        O_ACK,
  output logic [1:0]  O_EVT,
  output logic [11:0] O_X,
  output logic [11:0] O_Y,
  output logic [7:0]  ERR_CNT,
  output logic        DBG_STATE
);

  localparam int TW = $clog2(RELEASE_TIMEOUT + 1);
  localparam logic [TW-1:0] T_MAX = TW'(RELEASE_TIMEOUT);
  localparam int THW = TS_COORD_W + 1;
  localparam logic [THW-1:0] THRESH = THW'(MOVE_THRESH);

  ts_state_e       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [11:0]     last_x_q, last_x_d, last_y_q, last_y_d;
  logic            o_stb_q, o_stb_d;
  logic [1:0]      o_evt_q, o_evt_d;
  logic [11:0]     o_x_q, o_x_d, o_y_q, o_y_d;
  logic [7:0]      err_q, err_d;

  logic [11:0]     smp_x, smp_y;
  logic            word_ok, slot_free, accept, valid_acc, moved;
  logic [TW-1:0]   timer_inc;

  assign smp_x     = I_DAT[TS_X_MSB:TS_X_LSB];
  assign smp_y     = I_DAT[TS_Y_MSB:TS_Y_LSB];
  assign word_ok   = (I_DAT[TS_TAG_MSB:TS_TAG_LSB] == TS_TAG) &&
                     (I_DAT[TS_PAD_MSB:TS_PAD_LSB] == 4'h0);
  assign slot_free = ~o_stb_q | O_ACK;
  assign I_ACK     = ~RST & slot_free;
  assign accept    = I_STB & I_ACK;
  assign valid_acc = accept & word_ok;
  assign timer_inc = (timer_q == T_MAX) ? T_MAX : timer_q + 1'b1;

  touchscreen_delta_cmp u_delta (
    .new_x  (smp_x),
    .new_y  (smp_y),
    .last_x (last_x_q),
    .last_y (last_y_q),
    .thresh (THRESH),
    .moved  (moved)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    last_x_d = last_x_q;
    last_y_d = last_y_q;
    o_stb_d  = o_stb_q & ~O_ACK;
    o_evt_d  = o_evt_q;
    o_x_d    = o_x_q;
    o_y_d    = o_y_q;
    err_d    = err_q;

    if (accept && !word_ok && (err_q != 8'hFF)) err_d = err_q + 8'd1;

    case (state_q)
      TS_IDLE: begin
        if (valid_acc) begin
          o_stb_d  = 1'b1;
          o_evt_d  = TS_EVT_PRESS;
          o_x_d    = smp_x;
          o_y_d    = smp_y;
          last_x_d = smp_x;
          last_y_d = smp_y;
          timer_d  = '0;
          state_d  = TS_TOUCHED;
        end
      end
      TS_TOUCHED: begin
        if (valid_acc) begin
          timer_d = '0;
          if (moved) begin
            o_stb_d  = 1'b1;
            o_evt_d  = TS_EVT_MOVE;
            o_x_d    = smp_x;
            o_y_d    = smp_y;
            last_x_d = smp_x;
            last_y_d = smp_y;
          end
        end else begin
          timer_d = timer_inc;
          // A saturated timer waits here until the slot can take the RELEASE.
          if ((timer_inc == T_MAX) && slot_free) begin
            o_stb_d = 1'b1;
            o_evt_d = TS_EVT_RELEASE;
            o_x_d   = last_x_q;
            o_y_d   = last_y_q;
            timer_d = '0;
            state_d = TS_IDLE;
          end
        end
      end
      default: state_d = TS_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= TS_IDLE;
      timer_q  <= '0;
      last_x_q <= '0;
      last_y_q <= '0;
      o_stb_q  <= 1'b0;
      o_evt_q  <= '0;
      o_x_q    <= '0;
      o_y_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      last_x_q <= last_x_d;
      last_y_q <= last_y_d;
      o_stb_q  <= o_stb_d;
      o_evt_q  <= o_evt_d;
      o_x_q    <= o_x_d;
      o_y_q    <= o_y_d;
      err_q    <= err_d;
    end
  end

  assign O_STB     = o_stb_q;
  assign O_EVT     = o_evt_q;
  assign O_X       = o_x_q;
  assign O_Y       = o_y_q;
  assign ERR_CNT   = err_q;
  assign DBG_STATE = (state_q == TS_TOUCHED);

endmodule

// File: tb/tb_touchscreen_event_decoder.sv
// Bench for touchscreen_event_decoder: vector table, hand-written back-pressure/reset sequences, event scoreboard.
module tb_touchscreen_event_decoder;

  localparam int W = 26;
  localparam int TMO = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        I_STB = 1'b0;
  logic        I_ACK;
  logic [31:0] I_DAT = '0;
  logic        O_STB;
  logic        O_ACK = 1'b1;
  logic [1:0]  O_EVT;
  logic [11:0] O_X, O_Y;
  logic [7:0]  ERR_CNT;
  logic        DBG_STATE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  logic [W-1:0] exp_q[$];

  touchscreen_event_decoder #(.RELEASE_TIMEOUT(TMO), .MOVE_THRESH(4)) dut (
    .CLK(CLK), .RST(RST), .I_STB(I_STB), .I_ACK(I_ACK), .I_DAT(I_DAT),
    .O_STB(O_STB), .O_ACK(O_ACK), .O_EVT(O_EVT), .O_X(O_X), .O_Y(O_Y),
    .ERR_CNT(ERR_CNT), .DBG_STATE(DBG_STATE)
  );

  // clock / cycle counter / watchdog
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ev(input logic [1:0] e, input logic [11:0] x, input logic [11:0] y);
    return {e, x, y};
  endfunction

  // scoreboard: an event is consumed on the edge after a negedge where O_STB & O_ACK
  always @(negedge CLK) begin
    if (!RST && O_STB && O_ACK) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got %0h want none", {O_EVT, O_X, O_Y});
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({O_EVT, O_X, O_Y} !== e) begin
          errors++;
          $display("FAIL event got %0h want %0h", {O_EVT, O_X, O_Y}, e);
        end
      end
    end
  end

  // drivers: called #1 after a rising edge, return #1 after the accepting edge
  task automatic send_word(input logic [31:0] w);
    bit got = 0;
    I_DAT = w;
    I_STB = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (I_ACK) begin got = 1; break; end
    end
    if (!got) begin
      errors++;
      $display("FAIL send_ack got 0 want 1 word %0h", w);
    end
    @(posedge CLK); #1;
    I_STB = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic wait_release();
    bit seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (O_STB && O_EVT == 2'd3) begin seen = 1; break; end
    end
    chk("release_seen", 32'(seen), 32'd1);
    if (seen) chk("release_latency", cyc - last_valid_cyc, TMO);
    @(posedge CLK); #1;
  endtask

  task automatic hold_check(input logic [W-1:0] e, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      chk("hold_stb", 32'(O_STB), 32'd1);
      chk("hold_evt_xy", 32'({O_EVT, O_X, O_Y}), 32'(e));
      chk("hold_iack", 32'(I_ACK), 32'd0);
    end
    @(posedge CLK); #1;
  endtask

  typedef struct {
    logic [31:0] word;
    logic [1:0]  evt;
    logic [11:0] ex, ey;
    logic [7:0]  err;
    logic        rel;
    logic [11:0] rx, ry;
  } vec_t;

  vec_t vecs[11];
  int err_model;

  initial begin
    vecs[0]  = '{32'h8123_0456, 2'd1, 12'h123, 12'h456, 8'd0, 1'b0, 12'h0,   12'h0};
    vecs[1]  = '{32'h8125_0458, 2'd0, 12'h0,   12'h0,   8'd0, 1'b0, 12'h0,   12'h0};
    vecs[2]  = '{32'h812A_0456, 2'd2, 12'h12A, 12'h456, 8'd0, 1'b0, 12'h0,   12'h0};
    vecs[3]  = '{32'h8126_0456, 2'd0, 12'h0,   12'h0,   8'd0, 1'b0, 12'h0,   12'h0};
    vecs[4]  = '{32'h7123_0456, 2'd0, 12'h0,   12'h0,   8'd1, 1'b0, 12'h0,   12'h0};
    vecs[5]  = '{32'h8123_1456, 2'd0, 12'h0,   12'h0,   8'd2, 1'b1, 12'h12A, 12'h456};
    vecs[6]  = '{32'h8002_0010, 2'd1, 12'h002, 12'h010, 8'd2, 1'b0, 12'h0,   12'h0};
    vecs[7]  = '{32'h8FFE_0010, 2'd2, 12'hFFE, 12'h010, 8'd2, 1'b0, 12'h0,   12'h0};
    vecs[8]  = '{32'h8FFD_0011, 2'd0, 12'h0,   12'h0,   8'd2, 1'b0, 12'h0,   12'h0};
    vecs[9]  = '{32'h8FFD_0FFF, 2'd2, 12'hFFD, 12'hFFF, 8'd2, 1'b0, 12'h0,   12'h0};
    vecs[10] = '{32'h8001_0FFB, 2'd2, 12'h001, 12'hFFB, 8'd2, 1'b1, 12'h001, 12'hFFB};

    // reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_iack", 32'(I_ACK), 32'd0);
    chk("rst_ostb", 32'(O_STB), 32'd0);
    chk("rst_evt_xy", 32'({O_EVT, O_X, O_Y}), 32'd0);
    chk("rst_err", 32'(ERR_CNT), 32'd0);
    chk("rst_state", 32'(DBG_STATE), 32'd0);
    RST = 1'b0;
    idle(2);

    // table-driven vectors, O_ACK held high
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].evt != 2'd0) exp_q.push_back(ev(vecs[i].evt, vecs[i].ex, vecs[i].ey));
      send_word(vecs[i].word);
      if (vecs[i].word[31:28] == 4'h8 && vecs[i].word[15:12] == 4'h0) last_valid_cyc = cyc;
      chk("vec_ostb", 32'(O_STB), 32'(vecs[i].evt != 2'd0));
      chk("vec_err", 32'(ERR_CNT), 32'(vecs[i].err));
      if (vecs[i].rel) begin
        exp_q.push_back(ev(2'd3, vecs[i].rx, vecs[i].ry));
        wait_release();
        chk("rel_state", 32'(DBG_STATE), 32'd0);
      end
    end

    // back-pressure: timer saturates, RELEASE loads on the freeing edge
    O_ACK = 1'b0;
    exp_q.push_back(ev(2'd1, 12'h100, 12'h100));
    send_word(32'h8100_0100);
    hold_check(ev(2'd1, 12'h100, 12'h100), 12);
    exp_q.push_back(ev(2'd3, 12'h100, 12'h100));
    O_ACK = 1'b1;
    @(posedge CLK); #1;
    chk("pend_release", 32'({O_STB, O_EVT, O_X, O_Y}), 32'({1'b1, 2'd3, 12'h100, 12'h100}));
    idle(1);

    // back-pressure: a moving sample on the freeing edge beats the RELEASE
    O_ACK = 1'b0;
    exp_q.push_back(ev(2'd1, 12'h200, 12'h200));
    send_word(32'h8200_0200);
    hold_check(ev(2'd1, 12'h200, 12'h200), 12);
    exp_q.push_back(ev(2'd2, 12'h210, 12'h200));
    O_ACK = 1'b1;
    I_DAT = 32'h8210_0200;
    I_STB = 1'b1;
    @(posedge CLK); #1;
    I_STB = 1'b0;
    last_valid_cyc = cyc;
    chk("pend_move", 32'({O_STB, O_EVT, O_X, O_Y}), 32'({1'b1, 2'd2, 12'h210, 12'h200}));
    exp_q.push_back(ev(2'd3, 12'h210, 12'h200));
    wait_release();

    // back-pressure: a sub-threshold sample on the freeing edge gives nothing at all
    O_ACK = 1'b0;
    exp_q.push_back(ev(2'd1, 12'h400, 12'h400));
    send_word(32'h8400_0400);
    hold_check(ev(2'd1, 12'h400, 12'h400), 10);
    O_ACK = 1'b1;
    I_DAT = 32'h8401_0401;
    I_STB = 1'b1;
    @(posedge CLK); #1;
    I_STB = 1'b0;
    last_valid_cyc = cyc;
    chk("pend_none", 32'(O_STB), 32'd0);
    exp_q.push_back(ev(2'd3, 12'h400, 12'h400));
    wait_release();

    // error counter saturation
    err_model = 2;
    for (int i = 0; i < 300; i++) begin
      send_word(32'h0000_0000 | 32'(i));
      err_model = (err_model == 255) ? 255 : err_model + 1;
      if (i == 99) chk("err_mid", 32'(ERR_CNT), 32'(err_model));
    end
    chk("err_sat", 32'(ERR_CNT), 32'(err_model));

    // reset with an event pending
    O_ACK = 1'b0;
    send_word(32'h8300_0300);
    chk("pre_rst_stb", 32'(O_STB), 32'd1);
    chk("pre_rst_state", 32'(DBG_STATE), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_stb", 32'(O_STB), 32'd0);
    chk("mid_rst_err", 32'(ERR_CNT), 32'd0);
    chk("mid_rst_iack", 32'(I_ACK), 32'd0);
    chk("mid_rst_state", 32'(DBG_STATE), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    O_ACK = 1'b1;
    idle(1);
    exp_q.push_back(ev(2'd1, 12'h340, 12'h340));
    send_word(32'h8340_0340);
    last_valid_cyc = cyc;
    chk("post_rst_press", 32'({O_STB, O_EVT}), 32'({1'b1, 2'd1}));
    exp_q.push_back(ev(2'd3, 12'h340, 12'h340));
    wait_release();

    idle(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
